dbg_slave_sysclk_cmdq: RTL

Parametrised system-clock side of the debug-slave JTAG bridge. It synchronises the update-IR and update-DR strobes arriving from the TCK domain and captures each scanned data register with its instruction. Captured commands go into a small FIFO and are presented to the debug core over a valid/ready handshake. On each handshake it raises a one-hot take_action or take_no_action strobe per instruction. This generalises the fixed 38-bit, 2-bit-IR, unbuffered sysclk decoder in width, channel count and buffering depth.

---
 rtl/dbg_slave_sysclk_cmdq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dbg_slave_sysclk_cmdq.sv
// System-clock side of the debug-slave JTAG bridge: strobe synchronisers, a command FIFO and one-hot action strobes.
// Optional build macro DBG_SLAVE_CMDQ_TIMESTAMP_EN adds a free-running stamp to each queued command (cmd_ts).
module dbg_slave_sysclk_cmdq #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int QDEPTH      = 4,
  parameter int ACT_BIT     = 35
`ifdef DBG_SLAVE_CMDQ_TIMESTAMP_EN
  , parameter int TS_W      = 16
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IR_W-1:0]           ir_in,
  input  logic [SR_W-1:0]           sr,
  input  logic                      vs_uir,
  input  logic                      vs_udr,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [SR_W-1:0]           jdo,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [(2**IR_W)-1:0]      take_action,
  output logic [(2**IR_W)-1:0]      take_no_action,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      overflow,
  input  logic                      overflow_clr
`ifdef DBG_SLAVE_CMDQ_TIMESTAMP_EN
  , output logic [TS_W-1:0]         cmd_ts
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
`ifdef DBG_SLAVE_CMDQ_TIMESTAMP_EN
  localparam int EW = SR_W + IR_W + TS_W;
`else
  localparam int EW = SR_W + IR_W;
`endif

  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic                   r_uir_prev;
  logic                   r_udr_prev;
  logic [IR_W-1:0]        r_ir_q;
  logic [EW-1:0]          r_mem [QDEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_overflow;

  logic                   w_uir_edge;
  logic                   w_udr_edge;
  logic [IR_W-1:0]        w_ir_e;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [EW-1:0]          w_wdata;
  logic [EW-1:0]          w_head;

`ifdef DBG_SLAVE_CMDQ_TIMESTAMP_EN
  logic [TS_W-1:0]        r_ts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end
`endif

  // Chains reset high so a strobe already asserted at reset release is not seen as a new edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_uir_sync <= '1;
      r_udr_sync <= '1;
      r_uir_prev <= 1'b1;
      r_udr_prev <= 1'b1;
    end else begin
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
      r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
    end
  end

  assign w_uir_edge = r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;
  assign w_udr_edge = r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;

  // IR and DR updates in the same cycle must pair the data with the new instruction
  assign w_ir_e = w_uir_edge ? ir_in : r_ir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_ir_q <= '0;
    else if (w_uir_edge) r_ir_q <= ir_in;
  end

  assign w_full = (r_count == CW'(QDEPTH));
  assign w_pop  = cmd_valid & cmd_ready;
  assign w_push = w_udr_edge & (~w_full | w_pop);
  assign w_drop = w_udr_edge & w_full & ~w_pop;

`ifdef DBG_SLAVE_CMDQ_TIMESTAMP_EN
  assign w_wdata = {r_ts, w_ir_e, sr};
`else
  assign w_wdata = {w_ir_e, sr};
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  // Head fields are forced to zero while empty so storage needs no reset
  assign w_head    = r_mem[r_rd_ptr];
  assign cmd_valid = (r_count != '0);
  assign jdo       = cmd_valid ? w_head[SR_W-1:0] : '0;
  assign cmd_ir    = cmd_valid ? w_head[SR_W +: IR_W] : '0;
  assign q_count   = r_count;
  assign overflow  = r_overflow;
`ifdef DBG_SLAVE_CMDQ_TIMESTAMP_EN
  assign cmd_ts    = cmd_valid ? w_head[SR_W+IR_W +: TS_W] : '0;
`endif

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (w_pop) begin
      if (jdo[ACT_BIT]) take_action[cmd_ir]    = 1'b1;
      else              take_no_action[cmd_ir] = 1'b1;
    end
  end

endmodule
